// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: active-low one-hot column scan, debounced press/release, one code per press on valid/ready.
// Define KEYPAD_REPEAT_EN to add auto-repeat events while a key is held.
module keypad_scanner #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SETTLE       = 16,
    parameter int DEBOUNCE     = 1000,
    parameter int REPEAT_DELAY = 50000,
    parameter int REPEAT_RATE  = 10000,
    localparam int CW          = $clog2(ROWS*COLS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            key_pressed,
    output logic            overrun,
    input  logic            overrun_clr
);

    localparam int CIW     = $clog2(COLS);
    localparam int RIW     = $clog2(ROWS);
    localparam int CNT_MAX = (SETTLE > DEBOUNCE) ? SETTLE : DEBOUNCE;
    localparam int CNTW    = $clog2(CNT_MAX + 1);
    localparam logic [CNTW-1:0] SETTLE_LAST = CNTW'(SETTLE - 1);
    localparam logic [CNTW-1:0] DB_LAST     = CNTW'(DEBOUNCE - 1);

    if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || SETTLE < 1 || DEBOUNCE < 1 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("keypad_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD, S_RELEASE} state_t;

    state_t          state_q;
    logic [ROWS-1:0] row_s1_q, rs_q;
    logic [COLS-1:0] col_q;
    logic [CIW-1:0]  col_idx_q;
    logic [RIW-1:0]  row_idx_q;
    logic [CNTW-1:0] cnt_q;
    logic [CW-1:0]   key_code_q;
    logic            key_valid_q, key_pressed_q, overrun_q;

    logic [CIW-1:0]  col_nxt;
    logic [RIW-1:0]  low_row;
    logic            any_low, row_up, press_evt, emit;
    logic [CW-1:0]   code;

    function automatic logic [COLS-1:0] col_drive(input logic [CIW-1:0] c);
        col_drive = ~(COLS'(1) << c);
    endfunction

    assign col_nxt   = (col_idx_q == CIW'(COLS - 1)) ? '0 : col_idx_q + CIW'(1);
    assign row_up    = rs_q[row_idx_q];
    assign code      = CW'(int'(row_idx_q) * COLS + int'(col_idx_q));
    assign press_evt = (state_q == S_DEBOUNCE) && !row_up && (cnt_q == DB_LAST);

    // Lowest-index low row wins when several rows of one column are down.
    always_comb begin
        low_row = '0;
        any_low = 1'b0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!rs_q[i]) begin
                low_row = RIW'(i);
                any_low = 1'b1;
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPTW    = $clog2(RPT_MAX + 1);
    localparam logic [RPTW-1:0] DELAY_LAST = RPTW'(REPEAT_DELAY - 1);
    localparam logic [RPTW-1:0] RATE_LAST  = RPTW'(REPEAT_RATE - 1);

    logic [RPTW-1:0] rpt_cnt_q;
    logic            rpt_first_q;
    logic            rpt_evt;

    assign rpt_evt = (state_q == S_HELD) && !row_up &&
                     (rpt_cnt_q == (rpt_first_q ? DELAY_LAST : RATE_LAST));
    assign emit    = press_evt | rpt_evt;
`else
    assign emit    = press_evt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_SCAN;
            row_s1_q      <= '1;
            rs_q          <= '1;
            col_q         <= '1;
            col_idx_q     <= '0;
            row_idx_q     <= '0;
            cnt_q         <= '0;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt_q     <= '0;
            rpt_first_q   <= 1'b1;
`endif
        end else begin
            row_s1_q <= row;
            rs_q     <= row_s1_q;

            // A drop in the same cycle as a clear leaves overrun set.
            if (overrun_clr) overrun_q <= 1'b0;
            if (emit) begin
                if (!key_valid_q || key_ready) begin
                    key_code_q  <= code;
                    key_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (key_valid_q && key_ready) begin
                key_valid_q <= 1'b0;
            end

            case (state_q)
                S_SCAN: begin
                    if (col_q[col_idx_q]) begin
                        col_q <= col_drive(col_idx_q);
                    end else if (cnt_q == SETTLE_LAST) begin
                        cnt_q <= '0;
                        if (any_low) begin
                            row_idx_q <= low_row;
                            state_q   <= S_DEBOUNCE;
                        end else begin
                            col_idx_q <= col_nxt;
                            col_q     <= col_drive(col_nxt);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                S_DEBOUNCE: begin
                    if (row_up) begin
                        cnt_q     <= '0;
                        col_idx_q <= col_nxt;
                        col_q     <= col_drive(col_nxt);
                        state_q   <= S_SCAN;
                    end else if (cnt_q == DB_LAST) begin
                        cnt_q         <= '0;
                        key_pressed_q <= 1'b1;
                        state_q       <= S_HELD;
`ifdef KEYPAD_REPEAT_EN
                        rpt_cnt_q     <= '0;
                        rpt_first_q   <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                S_HELD: begin
                    if (row_up) begin
                        cnt_q   <= '0;
                        state_q <= S_RELEASE;
`ifdef KEYPAD_REPEAT_EN
                    end else if (rpt_evt) begin
                        rpt_cnt_q   <= '0;
                        rpt_first_q <= 1'b0;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q + RPTW'(1);
`endif
                    end
                end
                S_RELEASE: begin
                    if (!row_up) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        cnt_q         <= '0;
                        key_pressed_q <= 1'b0;
                        col_idx_q     <= col_nxt;
                        col_q         <= col_drive(col_nxt);
                        state_q       <= S_SCAN;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                default: state_q <= S_SCAN;
            endcase
        end
    end

    assign col         = col_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_pressed = key_pressed_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: physical keypad matrix model, expected-code scoreboard with a decoupled monitor,
// scan pattern, random presses, bounce, overrun, reset-in-HELD and (with KEYPAD_REPEAT_EN) auto-repeat timing.
`timescale 1ns/1ps
module tb_keypad_scanner;
    localparam int ROWS = 4, COLS = 4, SETTLE = 4, DEBOUNCE = 8, RDELAY = 40, RRATE = 10;
    localparam int CW = $clog2(ROWS*COLS);
    localparam int MASK = (1 << COLS) - 1;
    localparam int HOLD = 40, GAP = 30;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] col;
    logic [CW-1:0]   key_code;
    logic            key_valid, key_pressed, overrun;
    logic            key_ready = 1'b0;
    logic            overrun_clr = 1'b0;
    logic [ROWS-1:0] row_force = '1;
    bit              pressed [ROWS][COLS];

    int checks = 0, errors = 0, cyc = 0;
    int exp_q[$];
    int ev_t[$];

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SETTLE(SETTLE), .DEBOUNCE(DEBOUNCE),
        .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col), .key_code(key_code),
        .key_valid(key_valid), .key_ready(key_ready), .key_pressed(key_pressed),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Keypad matrix: a closed switch pulls its row low only while its column is driven low.
    always_comb begin
        row = row_force;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (pressed[r][c] && !col[c]) row[r] = 1'b0;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted handshake pops one expected code; key_code must not change while waiting.
    logic [CW-1:0] hold_code;
    bit            hold_vld = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_vld = 0;
        end else begin
            if (hold_vld && key_valid) chk("code_stable", key_code, hold_code);
            if (key_valid && key_ready) begin
                ev_t.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got code %0d, required no event", key_code);
                end else begin
                    chk("key_code", key_code, exp_q.pop_front());
                end
                hold_vld = 0;
            end else begin
                hold_vld  = key_valid;
                hold_code = key_code;
            end
        end
    end

    task automatic clear_keys();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) pressed[r][c] = 0;
    endtask

    task automatic press(input int ra, input int rb, input int c);
        pressed[ra][c] = 1;
        pressed[rb][c] = 1;
        tick(HOLD);
        chk("col_frozen", col, ~(1 << c) & MASK);
        chk("pressed_held", key_pressed, 1);
    endtask

    task automatic release_keys();
        clear_keys();
        tick(GAP);
        chk("released", key_pressed, 0);
    endtask

    task automatic wait_pressed(input string name);
        int n = 0;
        while (!key_pressed && n < 80) begin
            tick(1);
            n++;
        end
        if (!key_pressed) begin
            checks++;
            errors++;
            $display("FAIL %s: key_pressed still 0 after %0d cycles, required 1", name, n);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, r2, c, n;
        clear_keys();
        tick(3);
        chk("rst_col", col, MASK);
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_pressed", key_pressed, 0);
        chk("rst_overrun", overrun, 0);

        // Idle scan: each column low for SETTLE cycles, starting at column 0.
        rst_n = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            tick(1);
            chk("scan_col", col, ~(1 << (((k - 1) / SETTLE) % COLS)) & MASK);
            chk("idle_out", {key_valid, key_pressed}, 0);
        end

        key_ready = 1'b1;
        exp_q.push_back(2 * COLS + 1);
        press(2, 2, 1);
        release_keys();
        chk("drained_basic", exp_q.size(), 0);

        // Bounce shorter than the debounce window yields no event.
        for (int k = 0; k < 10; k++) begin
            row_force[0] = (k == 5 || k == 9) ? 1'b1 : 1'b0;
            tick(1);
            chk("bounce_no_press", key_pressed, 0);
        end
        row_force = '1;
        tick(GAP);
        chk("bounce_no_press_end", key_pressed, 0);

        for (int it = 0; it < 10; it++) begin
            c  = $urandom_range(0, COLS - 1);
            r  = $urandom_range(0, ROWS - 1);
            r2 = ($urandom_range(0, 1) == 1) ? $urandom_range(0, ROWS - 1) : r;
            exp_q.push_back(((r < r2) ? r : r2) * COLS + c);
            key_ready = 1'($urandom_range(0, 1));
            tick($urandom_range(0, 15));
            press(r, r2, c);
            key_ready = 1'b1;
            release_keys();
            chk("drained_rand", exp_q.size(), 0);
        end

        // Overrun: second press dropped while the first is still pending.
        key_ready = 1'b0;
        chk("ovr_init", overrun, 0);
        exp_q.push_back(2 * COLS + 1);
        press(2, 2, 1);
        release_keys();
        press(0, 0, 3);
        release_keys();
        chk("ovr_valid_kept", key_valid, 1);
        chk("ovr_code_kept", key_code, 2 * COLS + 1);
        chk("ovr_set", overrun, 1);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        chk("ovr_valid_cleared", key_valid, 0);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        chk("ovr_cleared", overrun, 0);
        exp_q.push_back(1 * COLS + 0);
        press(1, 1, 0);
        release_keys();
        chk("ovr_second_valid", key_valid, 1);
        overrun_clr = 1'b1;
        pressed[3][2] = 1;
        wait_pressed("ovr_wait");
        overrun_clr = 1'b0;
        chk("ovr_set_wins", overrun, 1);
        tick(HOLD);
        release_keys();
        chk("ovr_code_kept2", key_code, 1 * COLS + 0);
        key_ready = 1'b1;
        tick(2);
        chk("drained_ovr", exp_q.size(), 0);

        // Reset while HELD with an event pending: event is lost.
        key_ready = 1'b0;
        pressed[0][0] = 1;
        wait_pressed("rst_wait");
        chk("held_valid", key_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_col", col, MASK);
        chk("midrst_valid", key_valid, 0);
        chk("midrst_pressed", key_pressed, 0);
        clear_keys();
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_col0", col, ~1 & MASK);
        key_ready = 1'b1;
        tick(GAP);

`ifdef KEYPAD_REPEAT_EN
        for (int k = 0; k < 3; k++) exp_q.push_back(1 * COLS + 1);
        pressed[1][1] = 1;
        n = 0;
        while (!key_valid && n < 80) begin
            tick(1);
            n++;
        end
        chk("rpt_first_seen", key_valid, 1);
        tick(55);
        release_keys();
        chk("drained_rpt", exp_q.size(), 0);
        n = ev_t.size();
        if (n >= 3) begin
            chk("rpt_delay", ev_t[n-2] - ev_t[n-3], RDELAY);
            chk("rpt_rate", ev_t[n-1] - ev_t[n-2], RRATE);
        end else begin
            chk("rpt_event_count", n, 3);
        end
`endif

        chk("final_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
